// File: rtl/FetchUnitTypes.sv
// Shared types, encodings and size defaults for the fetch unit's gshare branch predictor.
package FetchUnitTypes;

    localparam int PHT_INDEX_WIDTH_DEFAULT = 8;
    localparam int GHR_WIDTH_DEFAULT       = 8;
    localparam int ADDR_WIDTH_DEFAULT      = 32;

    // Two-bit saturating direction counter; bit 1 is the predicted direction.
    typedef logic [1:0] PhtCounter;

    localparam PhtCounter PHT_STRONG_NT = 2'b00;
    localparam PhtCounter PHT_WEAK_NT   = 2'b01;
    localparam PhtCounter PHT_WEAK_T    = 2'b10;
    localparam PhtCounter PHT_STRONG_T  = 2'b11;

    typedef enum logic {
        PRED_INIT,
        PRED_RUN
    } PredState;

endpackage

// File: rtl/PhtCounterUpdate.sv
// Saturating next-value logic for one pattern history table counter.
module PhtCounterUpdate
    import FetchUnitTypes::*;
(
    input  PhtCounter counter,
    input  logic      taken,
    output PhtCounter nextCounter
);

    always_comb begin
        nextCounter = counter;
        if (taken) begin
            if (counter != PHT_STRONG_T) nextCounter = counter + 2'd1;
        end else begin
            if (counter != PHT_STRONG_NT) nextCounter = counter - 2'd1;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PC xor global history indexes a table of 2-bit counters,
// with speculative history update at fetch and history repair on mispredict.
module gshare_predictor
    import FetchUnitTypes::*;
#(
    parameter int PHT_INDEX_WIDTH = PHT_INDEX_WIDTH_DEFAULT,
    parameter int GHR_WIDTH       = GHR_WIDTH_DEFAULT,
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] fetchPc,
    input  logic                  fetchValid,
    input  logic                  fetchStall,
    input  logic                  fetchIsBranch,
    output logic                  isBranchTakenPredicted,
    output logic                  predictValid,
    output logic [GHR_WIDTH-1:0]  predictGhr,
    input  logic                  resolveValid,
    input  logic [ADDR_WIDTH-1:0] resolvePc,
    input  logic [GHR_WIDTH-1:0]  resolveGhr,
    input  logic                  resolveTaken,
    input  logic                  resolveMispredict,
    output logic                  ready
);

    localparam int PHT_ENTRIES = 1 << PHT_INDEX_WIDTH;

    typedef logic [PHT_INDEX_WIDTH-1:0] pht_idx_t;
    typedef logic [GHR_WIDTH-1:0]       ghr_t;

    localparam pht_idx_t INIT_LAST = '1;

    PredState  state_q, state_d;
    pht_idx_t  init_idx_q, init_idx_d;
    ghr_t      ghr_q, ghr_d;
    ghr_t      pred_ghr_q, pred_ghr_d;
    logic      pred_taken_q, pred_taken_d;
    logic      pred_valid_q, pred_valid_d;
    PhtCounter pht_q [PHT_ENTRIES];

    logic      running;
    logic      recover;
    logic      fetch_accept;
    logic      spec_shift;
    pht_idx_t  lookup_idx;
    pht_idx_t  update_idx;
    pht_idx_t  pht_widx;
    PhtCounter pht_wdata;
    logic      pht_we;
    PhtCounter update_cur;
    PhtCounter update_next;
    logic      unused_pc_bits;

    assign lookup_idx = fetchPc[PHT_INDEX_WIDTH+1:2] ^ pht_idx_t'(ghr_q);
    assign update_idx = resolvePc[PHT_INDEX_WIDTH+1:2] ^ pht_idx_t'(resolveGhr);
    assign update_cur = pht_q[update_idx];

    assign unused_pc_bits = ^{fetchPc[ADDR_WIDTH-1:PHT_INDEX_WIDTH+2], fetchPc[1:0],
                              resolvePc[ADDR_WIDTH-1:PHT_INDEX_WIDTH+2], resolvePc[1:0]};

    assign recover      = running && resolveValid && resolveMispredict;
    assign fetch_accept = running && fetchValid && !fetchStall;
    assign spec_shift   = running && pred_valid_q && fetchIsBranch && !fetchStall;

    PhtCounterUpdate u_counter_update (
        .counter     (update_cur),
        .taken       (resolveTaken),
        .nextCounter (update_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PRED_INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    // The init walk parks on the last index instead of wrapping.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        if (state_q == PRED_INIT) begin
            if (init_idx_q == INIT_LAST) state_d = PRED_RUN;
            else                         init_idx_d = init_idx_q + pht_idx_t'(1);
        end
    end

    always_comb begin
        running = (state_q == PRED_RUN);
        ready   = running;
    end

    // One write port shared by the init sweep and branch resolution.
    always_comb begin
        pht_we    = 1'b0;
        pht_widx  = init_idx_q;
        pht_wdata = PHT_WEAK_NT;
        if (!running) begin
            pht_we = 1'b1;
        end else if (resolveValid) begin
            pht_we    = 1'b1;
            pht_widx  = update_idx;
            pht_wdata = update_next;
        end
    end

    // NOTE: the table has no reset; the INIT sweep writes every entry before any lookup is accepted.
    always_ff @(posedge clk) begin
        if (pht_we) pht_q[pht_widx] <= pht_wdata;
    end

    // Lookup samples pht_q before this edge's write lands, giving read-first behaviour.
    always_comb begin
        ghr_d        = ghr_q;
        pred_ghr_d   = pred_ghr_q;
        pred_taken_d = pred_taken_q;
        pred_valid_d = pred_valid_q;
        if (recover) begin
            ghr_d        = {resolveGhr[GHR_WIDTH-2:0], resolveTaken};
            pred_valid_d = 1'b0;
        end else begin
            if (spec_shift) ghr_d = {ghr_q[GHR_WIDTH-2:0], pred_taken_q};
            if (running && !fetchStall) begin
                pred_valid_d = fetch_accept;
                if (fetch_accept) begin
                    pred_taken_d = pht_q[lookup_idx][1];
                    pred_ghr_d   = ghr_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q        <= '0;
            pred_ghr_q   <= '0;
            pred_taken_q <= 1'b0;
            pred_valid_q <= 1'b0;
        end else begin
            ghr_q        <= ghr_d;
            pred_ghr_q   <= pred_ghr_d;
            pred_taken_q <= pred_taken_d;
            pred_valid_q <= pred_valid_d;
        end
    end

    assign isBranchTakenPredicted = pred_taken_q;
    assign predictValid           = pred_valid_q;
    assign predictGhr             = pred_ghr_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: init timing, training, saturation, history
// speculation and recovery, read-first conflicts, stall hold and reset during init.
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetchPc;
    logic        fetchValid;
    logic        fetchStall;
    logic        fetchIsBranch;
    logic        isBranchTakenPredicted;
    logic        predictValid;
    logic [7:0]  predictGhr;
    logic        resolveValid;
    logic [31:0] resolvePc;
    logic [7:0]  resolveGhr;
    logic        resolveTaken;
    logic        resolveMispredict;
    logic        ready;

    int n_compared   = 0;
    int n_mismatched = 0;

    gshare_predictor dut (
        .clk                    (clk),
        .rst                    (rst),
        .fetchPc                (fetchPc),
        .fetchValid             (fetchValid),
        .fetchStall             (fetchStall),
        .fetchIsBranch          (fetchIsBranch),
        .isBranchTakenPredicted (isBranchTakenPredicted),
        .predictValid           (predictValid),
        .predictGhr             (predictGhr),
        .resolveValid           (resolveValid),
        .resolvePc              (resolvePc),
        .resolveGhr             (resolveGhr),
        .resolveTaken           (resolveTaken),
        .resolveMispredict      (resolveMispredict),
        .ready                  (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] pc);
        fetchPc    = pc;
        fetchValid = 1'b1;
        tick();
        fetchValid = 1'b0;
    endtask

    task automatic do_resolve(input logic [31:0] pc, input logic [7:0] ghr,
                              input logic taken, input logic mis);
        resolvePc         = pc;
        resolveGhr        = ghr;
        resolveTaken      = taken;
        resolveMispredict = mis;
        resolveValid      = 1'b1;
        tick();
        resolveValid      = 1'b0;
        resolveMispredict = 1'b0;
    endtask

    // Counts cycles until ready rises, bounded so a stuck INIT still ends the run.
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!ready && cycles < 400) begin
            tick();
            cycles++;
            if (cycles == 128) begin
                check("init_pvalid", predictValid, 0);
                check("init_taken", isBranchTakenPredicted, 0);
            end
        end
    endtask

    initial begin
        int cycles;
        rst               = 1'b1;
        fetchPc           = '0;
        fetchValid        = 1'b0;
        fetchStall        = 1'b0;
        fetchIsBranch     = 1'b0;
        resolveValid      = 1'b0;
        resolvePc         = '0;
        resolveGhr        = '0;
        resolveTaken      = 1'b0;
        resolveMispredict = 1'b0;

        // Reset state
        tick();
        check("rst_ready", ready, 0);
        check("rst_pvalid", predictValid, 0);
        check("rst_taken", isBranchTakenPredicted, 0);
        check("rst_pghr", predictGhr, 0);

        // INIT must ignore fetches and mispredict resolves
        rst               = 1'b0;
        fetchPc           = 32'h100;
        fetchValid        = 1'b1;
        resolvePc         = 32'h100;
        resolveGhr        = 8'hFF;
        resolveTaken      = 1'b1;
        resolveMispredict = 1'b1;
        resolveValid      = 1'b1;
        wait_ready(cycles);
        fetchValid        = 1'b0;
        resolveValid      = 1'b0;
        resolveMispredict = 1'b0;
        check("init_cycles", cycles, 256);
        check("ready_up", ready, 1);

        // First prediction from a freshly initialised table
        do_fetch(32'h100);
        check("first_pvalid", predictValid, 1);
        check("first_taken", isBranchTakenPredicted, 0);
        check("first_pghr", predictGhr, 0);
        tick();
        check("idle_pvalid", predictValid, 0);

        // Training at index 0x40: 01 -> 10 -> 11
        do_resolve(32'h100, 8'h00, 1'b1, 1'b0);
        do_resolve(32'h100, 8'h00, 1'b1, 1'b0);
        do_fetch(32'h100);
        check("trained_taken", isBranchTakenPredicted, 1);

        // Top saturation: 11 stays 11, one decrement leaves it taken
        do_resolve(32'h100, 8'h00, 1'b1, 1'b0);
        do_resolve(32'h100, 8'h00, 1'b1, 1'b0);
        do_resolve(32'h100, 8'h00, 1'b0, 1'b0);
        do_fetch(32'h100);
        check("sat_top_taken", isBranchTakenPredicted, 1);
        do_resolve(32'h100, 8'h00, 1'b0, 1'b0);
        do_fetch(32'h100);
        check("weak_nt_taken", isBranchTakenPredicted, 0);

        // Read-first: lookup and taken update to the same entry (01 -> 10)
        resolvePc    = 32'h100;
        resolveGhr   = 8'h00;
        resolveTaken = 1'b1;
        resolveValid = 1'b1;
        do_fetch(32'h100);
        resolveValid = 1'b0;
        check("read_first_old", isBranchTakenPredicted, 0);
        do_fetch(32'h100);
        check("read_first_new", isBranchTakenPredicted, 1);

        // Bottom saturation: 10 -> 01 -> 00 -> 00, then taken -> 01
        do_resolve(32'h100, 8'h00, 1'b0, 1'b0);
        do_resolve(32'h100, 8'h00, 1'b0, 1'b0);
        do_resolve(32'h100, 8'h00, 1'b0, 1'b0);
        do_resolve(32'h100, 8'h00, 1'b1, 1'b0);
        do_fetch(32'h100);
        check("sat_bottom_taken", isBranchTakenPredicted, 0);

        // Speculative shift: entry 0x40 -> 10, predicted-taken branch moves GHR to 0x01
        do_resolve(32'h100, 8'h00, 1'b1, 1'b0);
        do_fetch(32'h100);
        check("spec_pred_taken", isBranchTakenPredicted, 1);
        fetchIsBranch = 1'b1;
        tick();
        fetchIsBranch = 1'b0;
        do_fetch(32'h104);
        check("spec_pghr", predictGhr, 8'h01);
        check("spec_hashed_taken", isBranchTakenPredicted, 1);

        // Mispredict recovery to 0x00 kills the prediction accepted in the same cycle
        fetchPc    = 32'h100;
        fetchValid = 1'b1;
        do_resolve(32'h200, 8'h00, 1'b0, 1'b1);
        fetchValid = 1'b0;
        check("recover_pvalid", predictValid, 0);
        do_fetch(32'h100);
        check("recover_pghr", predictGhr, 8'h00);
        check("recover_taken", isBranchTakenPredicted, 1);

        // Recovery beats a same-cycle speculative shift: GHR = {0x05[6:0], 1} = 0x0B
        fetchIsBranch = 1'b1;
        do_resolve(32'h300, 8'h05, 1'b1, 1'b1);
        fetchIsBranch = 1'b0;
        check("conflict_pvalid", predictValid, 0);
        do_fetch(32'h100);
        check("conflict_pghr", predictGhr, 8'h0B);
        check("conflict_taken", isBranchTakenPredicted, 0);
        do_fetch(32'h12C);
        check("hash_0b_taken", isBranchTakenPredicted, 1);

        // Stall holds all prediction outputs and suppresses the history shift
        fetchStall    = 1'b1;
        fetchValid    = 1'b1;
        fetchPc       = 32'h100;
        fetchIsBranch = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pvalid", predictValid, 1);
            check("stall_taken", isBranchTakenPredicted, 1);
            check("stall_pghr", predictGhr, 8'h0B);
        end
        fetchStall    = 1'b0;
        fetchIsBranch = 1'b0;
        do_fetch(32'h12C);
        check("post_stall_pghr", predictGhr, 8'h0B);

        // Reset mid-operation, then again at INIT cycle 100
        rst = 1'b1;
        tick();
        check("rst2_ready", ready, 0);
        check("rst2_pvalid", predictValid, 0);
        check("rst2_taken", isBranchTakenPredicted, 0);
        check("rst2_pghr", predictGhr, 0);
        rst = 1'b0;
        repeat (100) tick();
        check("mid_init_ready", ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready(cycles);
        check("reinit_cycles", cycles, 256);
        do_fetch(32'h100);
        check("reinit_pvalid", predictValid, 1);
        check("reinit_taken", isBranchTakenPredicted, 0);
        check("reinit_pghr", predictGhr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
